lsu_wb: RTL and testbench
=========================

Name: lsu_wb

Overview:
- Load/store unit and writeback stage directly upstream of the register file write port.
- Accepts one memory op at a time from EXU and runs it over a valid/ready memory interface.
- Byte-aligns and sign/zero-extends load data, then drives rf_wen/rf_waddr/rf_wdata for exactly one cycle.
- Stores and faulting ops complete with a done pulse and no register write.

Parameters:
- MAX_WAIT, 255: response-wait cycles in RSP before timeout error; counter width is clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- in_valid  in  1  EXU op valid.
- in_ready  out  1  op accepted when in_valid && in_ready.
- in_wr  in  1  1=store, 0=load.
- in_funct3  in  3  RV32 width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- in_addr  in  32  byte address.
- in_wdata  in  32  store data (rs2).
- in_rd  in  5  load destination register.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wen  out  1  1=write request.
- mem_wdata  out  32  lane-replicated store data.
- mem_wmask  out  4  byte enables (0 for loads).
- mem_rsp_valid  in  1  load response valid.
- mem_rdata  in  32  load response word.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: misaligned, illegal funct3, or timeout.

Behaviour:
- States: IDLE, REQ, RSP, WB. Reset (async) forces IDLE, counter 0, all captured regs 0; every output 0 except in_ready=1. An in-flight op is discarded and mem_req_valid drops immediately.
- in_ready = (state==IDLE), combinational from state.
- IDLE: on accept, latch wr, funct3, addr, wdata, rd.
  - Illegal op: funct3 not in {000,001,010,100,101}, or store with funct3[2]=1. Set err_q=1 and go to WB.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. Set err_q=1 and go to WB.
  - Otherwise clear err_q and go to REQ.
- REQ: mem_req_valid=1; mem_addr, mem_wen, mem_wdata, mem_wmask held stable until mem_req_ready.
  - On handshake, a store goes to WB; a load clears the counter and goes to RSP.
  - mem_rsp_valid is ignored in REQ.
- RSP: sample mem_rsp_valid each cycle.
  - If set: latch the extended data and go to WB.
  - Else if counter==MAX_WAIT: set err_q and go to WB.
  - Else increment the counter.
- WB, exactly one cycle, then IDLE:
  - done=1 and err=err_q.
  - rf_wen = !wr && !err_q && rd!=0.
  - rf_waddr = rd and rf_wdata = loaded value; both are 0 whenever rf_wen=0.
- Store lanes, with o = addr[1:0]:
  - SB: wdata={4{b[7:0]}}, wmask=4'b0001<<o.
  - SH: wdata={2{h[15:0]}}, wmask=4'b0011<<o.
  - SW: wdata=in_wdata, wmask=4'b1111.
- Load extract: byte = rdata[8*o+:8]; half = rdata[16*o[1]+:16]. B/H sign-extend, BU/HU zero-extend, W passes through.
- Latency for an aligned load with mem_req_ready=1 and the response one cycle after the handshake: accept at cycle 0, handshake at cycle 1, response at cycle 2, rf_wen at cycle 3.
- A store with ready=1 gives done at cycle 2. A faulting op gives done+err at cycle 1.
- Outputs in all non-listed states: done=0, err=0, rf_wen=0, mem_req_valid=0.

Test Plan:
- LB at addr 0x8000_0003, mem_rdata=0x80FF_FF7F, rd=5: mem_addr=0x8000_0000, wmask=0, then rf_wen=1, waddr=5, wdata=0xFFFF_FF80, done=1, err=0, exactly 3 cycles after accept.
- LHU at 0x...02 with rdata=0x8001_1234 gives wdata=0x0000_8001. LH at 0x...00 with rdata=0x0000_F234 gives 0xFFFF_F234. LW with rd=0 gives done=1, rf_wen=0.
- SB at 0x...01 with in_wdata=0x1122_33AB: mem_wdata=0xABAB_ABAB, wmask=4'b0010, wen=1. Hold mem_req_ready=0 for 4 cycles: request stays stable; done 1 cycle after handshake; rf_wen never 1.
- LW at 0x...02, and separately funct3=011: no mem_req_valid, done=1, err=1 one cycle after accept, in_ready=0 during WB.
- Load with mem_rsp_valid never asserted, MAX_WAIT=4: done=1, err=1, rf_wen=0 after 5 RSP cycles; next op accepted normally.
- Assert rst while in REQ and while in RSP: mem_req_valid=0 and in_ready=1 immediately; a late mem_rsp_valid after release causes no rf_wen.

Source files
------------

// File: rtl/lsu_wb.sv
// ============================================================================
// Module   : lsu_wb
// Function : Single-op load/store unit with byte-lane alignment, load
//            extension and a one-cycle register-file writeback.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_wb #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // EXU op
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wr,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  // memory request/response
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  // register file write port
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        done,
  output logic        err
);

  localparam int c_cnt_w = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic               r_wr;
  logic [2:0]         r_funct3;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [4:0]         r_rd;
  logic               r_err;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_ldata;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_fault;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_ld_cap;
  logic        w_timeout;
  logic        w_req;
  logic        w_wb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_ext;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_wmask;

  // Op classification is done on the incoming fields so a faulting op
  // can skip straight to writeback.
  always_comb begin
    w_illegal = 1'b0;
    case (in_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b100, 3'b101:         w_illegal = in_wr;
      default:                w_illegal = 1'b1;
    endcase
  end

  assign w_misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                      ((in_funct3 == 3'b010) && (in_addr[1:0] != 2'b00));
  assign w_fault    = w_illegal || w_misalign;
  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_timeout  = (r_cnt == c_max_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_ld_cap    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = w_fault ? S_WB : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = r_wr ? S_WB : S_RSP;
          w_cnt_clr   = !r_wr;
        end
      end
      S_RSP: begin
        if (mem_rsp_valid) begin
          w_ld_cap    = 1'b1;
          w_state_nxt = S_WB;
        end else if (w_timeout) begin
          w_state_nxt = S_WB;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_WB: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rd     <= 5'd0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_ldata  <= 32'h0;
    end else begin
      if (w_accept) begin
        r_wr     <= in_wr;
        r_funct3 <= in_funct3;
        r_addr   <= in_addr;
        r_wdata  <= in_wdata;
        r_rd     <= in_rd;
        r_err    <= w_fault;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_ld_cap) begin
        r_ldata <= w_ld_ext;
      end
      if ((r_state == S_RSP) && !mem_rsp_valid && w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Load lane select: halves are always 2-byte aligned once we get here.
  assign w_byte = mem_rdata[8*r_addr[1:0] +: 8];
  assign w_half = mem_rdata[16*r_addr[1] +: 16];

  always_comb begin
    w_ld_ext = mem_rdata;
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_ext = {24'h0, w_byte};
      3'b101:  w_ld_ext = {16'h0, w_half};
      default: w_ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_st_wdata = r_wdata;
    w_st_wmask = 4'b1111;
    case (r_funct3[1:0])
      2'b00: begin
        w_st_wdata = {4{r_wdata[7:0]}};
        w_st_wmask = 4'b0001 << r_addr[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{r_wdata[15:0]}};
        w_st_wmask = 4'b0011 << r_addr[1:0];
      end
      default: begin
        w_st_wdata = r_wdata;
        w_st_wmask = 4'b1111;
      end
    endcase
  end

  assign w_req = (r_state == S_REQ);
  assign w_wb  = (r_state == S_WB);

  assign in_ready      = (r_state == S_IDLE);
  assign mem_req_valid = w_req;
  assign mem_addr      = w_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem_wen       = w_req && r_wr;
  assign mem_wdata     = (w_req && r_wr) ? w_st_wdata : 32'h0;
  assign mem_wmask     = (w_req && r_wr) ? w_st_wmask : 4'b0000;

  assign done     = w_wb;
  assign err      = w_wb && r_err;
  assign rf_wen   = w_wb && !r_wr && !r_err && (r_rd != 5'd0);
  assign rf_waddr = rf_wen ? r_rd : 5'd0;
  assign rf_wdata = rf_wen ? r_ldata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_wb.sv
// ============================================================================
// Module   : tb_lsu_wb
// Function : Randomized self-checking bench for lsu_wb against a behavioural
//            op-level model with a per-cycle expected-output schedule.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_wb;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wr = 1'b0;
  logic [2:0]  in_funct3 = 3'b000;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_wdata = 32'h0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done;
  logic        err;

  lsu_wb #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Expected outputs for the current cycle
  logic        e_in_ready, e_req_valid, e_wen, e_done, e_err, e_rf_wen;
  logic [31:0] e_mem_addr, e_wdata, e_rf_wdata;
  logic [3:0]  e_wmask;
  logic [4:0]  e_waddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_legal(input logic wr, input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) return 1'b1;
    if (f3 == 3'd4 || f3 == 3'd5) return !wr;
    return 1'b0;
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << m_size(f3)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_swdata(input logic [2:0] f3, input logic [31:0] d);
    if (m_size(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (m_size(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [31:0] sh, mask, v;
    int bits;
    bits = 8 * m_size(f3);
    if (bits == 32) return rdata;
    sh   = rdata >> (8 * (addr % 4));
    mask = (32'd1 << bits) - 32'd1;
    v    = sh & mask;
    if (!f3[2] && ((v >> (bits - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, e_in_ready);
      check("mem_req_valid", mem_req_valid, e_req_valid);
      if (e_req_valid) begin
        check("mem_addr", mem_addr, e_mem_addr);
        check("mem_wen", mem_wen, e_wen);
        check("mem_wmask", mem_wmask, e_wmask);
        if (e_wen) check("mem_wdata", mem_wdata, e_wdata);
      end
      check("done", done, e_done);
      check("err", err, e_err);
      check("rf_wen", rf_wen, e_rf_wen);
      check("rf_waddr", rf_waddr, e_waddr);
      check("rf_wdata", rf_wdata, e_rf_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_in_ready = 1'b1; e_req_valid = 1'b0; e_mem_addr = 32'h0; e_wen = 1'b0;
    e_wdata = 32'h0; e_wmask = 4'h0; e_done = 1'b0; e_err = 1'b0;
    e_rf_wen = 1'b0; e_waddr = 5'd0; e_rf_wdata = 32'h0;
  endtask

  task automatic scramble_inputs();
    in_valid  = 1'($urandom_range(0, 1));
    in_wr     = 1'($urandom_range(0, 1));
    in_funct3 = 3'($urandom_range(0, 7));
    in_addr   = $urandom;
    in_wdata  = $urandom;
    in_rd     = 5'($urandom_range(0, 31));
  endtask

  // rsp_dly < 0 means the response never arrives
  task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                        input logic lit_en, input logic [31:0] lit);
    int n;
    set_idle();
    in_valid = 1'b1; in_wr = wr; in_funct3 = f3; in_addr = addr;
    in_wdata = wdata; in_rd = rd;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    tick();
    scramble_inputs();
    e_in_ready = 1'b0;
    if (!m_legal(wr, f3) || m_misaligned(f3, addr)) begin
      e_done = 1'b1; e_err = 1'b1;
      tick();
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        e_req_valid = 1'b1;
        e_mem_addr  = addr & 32'hFFFF_FFFC;
        e_wen       = wr;
        e_wdata     = m_swdata(f3, wdata);
        e_wmask     = wr ? m_mask(f3, addr) : 4'h0;
        mem_req_ready = (k == rdy_dly);
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rdata     = $urandom;
        if (lit_en && wr && k == 0) begin
          @(negedge clk);
          check("lit_store_wdata", mem_wdata, lit);
        end
        tick();
      end
      e_req_valid = 1'b0;
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = 1'b0;
      if (wr) begin
        e_done = 1'b1;
        tick();
      end else begin
        n = (rsp_dly < 0) ? MW + 1 : rsp_dly + 1;
        for (int k = 0; k < n; k++) begin
          mem_rsp_valid = (k == rsp_dly);
          mem_rdata     = (k == rsp_dly) ? rdata : $urandom;
          tick();
        end
        mem_rsp_valid = 1'b0;
        e_done = 1'b1;
        if (rsp_dly < 0) begin
          e_err = 1'b1;
        end else if (rd != 5'd0) begin
          e_rf_wen = 1'b1; e_waddr = rd; e_rf_wdata = m_load(f3, addr, rdata);
        end
        if (lit_en) begin
          @(negedge clk);
          check("lit_load_wdata", rf_wdata, lit);
        end
        tick();
      end
    end
    in_valid = 1'b0;
    set_idle();
  endtask

  task automatic rst_test(input bit in_rsp);
    set_idle();
    in_valid = 1'b1; in_wr = 1'b0; in_funct3 = 3'b010; in_addr = 32'h4000_0010;
    in_rd = 5'd7; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    tick();
    in_valid = 1'b0;
    e_in_ready = 1'b0; e_req_valid = 1'b1; e_mem_addr = 32'h4000_0010; e_wen = 1'b0;
    e_wmask = 4'h0;
    mem_req_ready = in_rsp;
    if (in_rsp) begin
      tick();
      e_req_valid = 1'b0;
      mem_req_ready = 1'b0;
    end
    #1;
    rst = 1'b1;
    set_idle();
    #1;
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    tick();
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = $urandom;
    tick();
    tick();
    mem_rsp_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          rsp;
    set_idle();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // directed cases
    run_op(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd5, 0, 0, 32'h80FF_FF7F, 1'b1, 32'hFFFF_FF80);
    run_op(1'b0, 3'b101, 32'h1000_0002, 32'h0, 5'd9, 0, 0, 32'h8001_1234, 1'b1, 32'h0000_8001);
    run_op(1'b0, 3'b001, 32'h1000_0000, 32'h0, 5'd3, 1, 2, 32'h0000_F234, 1'b1, 32'hFFFF_F234);
    run_op(1'b0, 3'b010, 32'h1000_0008, 32'h0, 5'd0, 0, 0, 32'h1234_5678, 1'b1, 32'h0);
    run_op(1'b1, 3'b000, 32'h2000_0001, 32'h1122_33AB, 5'd4, 4, 0, 32'h0, 1'b1, 32'hABAB_ABAB);
    run_op(1'b0, 3'b010, 32'h3000_0002, 32'h0, 5'd6, 0, 0, 32'h0, 1'b0, 32'h0);
    run_op(1'b0, 3'b011, 32'h3000_0000, 32'h0, 5'd6, 0, 0, 32'h0, 1'b0, 32'h0);
    run_op(1'b0, 3'b010, 32'h5000_0004, 32'h0, 5'd8, 0, -1, 32'h0, 1'b0, 32'h0);
    run_op(1'b0, 3'b100, 32'h5000_0005, 32'h0, 5'd8, 0, MW, 32'hA5C3_9E11, 1'b1, 32'h0000_009E);
    rst_test(1'b0);
    rst_test(1'b1);

    // randomized ops
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr = $urandom;
      if ($urandom_range(0, 9) < 7) addr = addr & ~(32'(m_size(f3)) - 32'd1);
      rsp = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, MW));
      run_op(wr, f3, addr, $urandom, 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 3)), rsp, $urandom, 1'b0, 32'h0);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
    end

    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
